// File: rtl/l2_bus_pkg.sv
// Shared types and encodings for the L2 bus arbiter: FSM states, L2 opcodes and hit codes.
package l2_bus_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STORE     = 3'd2,
    MISS_WAIT = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_NONE  = 7'b0000000;

  localparam logic [1:0] HIT     = 2'b10;
  localparam logic [1:0] MISS    = 2'b01;
  localparam logic [1:0] NEUTRAL = 2'b00;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping around.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cidx;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cidx  = '0;
    for (int i = 0; i < N; i++) begin
      cidx = IW'((int'(ptr) + i) % N);
      if (!any && req[cidx]) begin
        any         = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Round-robin sequencer sharing the single L2 port among NUM_CORES L1 controllers,
// one outstanding request at a time, with miss refill wait and timeout error response.
module l2_bus_arbiter
  import l2_bus_pkg::*;
#(
  parameter int NUM_CORES    = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MISS_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES-1:0]          req_is_store,
  input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   req_data,
  output logic [NUM_CORES-1:0]          req_ready,
  output logic [NUM_CORES-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_err,
  output logic [6:0]                    l2_opcode,
  output logic                          l2_flush,
  output logic [ADDR_W-1:0]             l2_bus_address,
  output logic [DATA_W-1:0]             l2_bus_data,
  output logic [23:0]                   l2_bus_tag,
  input  logic [1:0]                    l2_hit,
  input  logic [DATA_W-1:0]             l2_data,
  output logic                          busy,
  output arb_state_t                    state_dbg
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  core_id;
  logic [CNT_W-1:0]  miss_cnt;

  logic [NUM_CORES-1:0] pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  rr_priority_picker #(
    .N  (NUM_CORES),
    .IW (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Handshake: a request on core i is accepted in the cycle where req_valid[i] and
  // req_ready[i] are both high; req_ready only pulses while IDLE, so a request is
  // accepted at most once and the requester must hold req_valid until then.
  assign req_ready  = (state == IDLE && !reset) ? pick_grant : '0;
  assign l2_bus_tag = l2_bus_address[ADDR_W-1:ADDR_W-24];
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      core_id        <= '0;
      miss_cnt       <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      l2_opcode      <= OPC_NONE;
      l2_flush       <= 1'b0;
      l2_bus_address <= '0;
      l2_bus_data    <= '0;
    end else begin
      rsp_valid <= '0;
      l2_flush  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            core_id        <= pick_idx;
            l2_bus_address <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            l2_bus_data    <= req_data[pick_idx*DATA_W +: DATA_W];
            if (req_is_store[pick_idx]) begin
              state     <= STORE;
              l2_flush  <= 1'b1;
              l2_opcode <= OPC_NONE;
            end else begin
              state     <= LOAD;
              l2_opcode <= OPC_LOAD;
            end
          end
        end
        STORE: begin
          state     <= RESP;
          rsp_valid <= NUM_CORES'(1) << core_id;
          rsp_data  <= '0;
          rsp_err   <= 1'b0;
        end
        LOAD: begin
          // Anything other than a hit here, including the illegal neutral code, waits for refill.
          if (l2_hit == HIT) begin
            state     <= RESP;
            rsp_valid <= NUM_CORES'(1) << core_id;
            rsp_data  <= l2_data;
            rsp_err   <= 1'b0;
            l2_opcode <= OPC_NONE;
          end else begin
            state    <= MISS_WAIT;
            miss_cnt <= '0;
          end
        end
        MISS_WAIT: begin
          if (l2_hit == HIT) begin
            state     <= RESP;
            rsp_valid <= NUM_CORES'(1) << core_id;
            rsp_data  <= l2_data;
            rsp_err   <= 1'b0;
            l2_opcode <= OPC_NONE;
          end else if (miss_cnt == CNT_W'(MISS_TIMEOUT - 1)) begin
            state     <= RESP;
            rsp_valid <= NUM_CORES'(1) << core_id;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            l2_opcode <= OPC_NONE;
          end else begin
            miss_cnt <= miss_cnt + 1'b1;
          end
        end
        RESP: begin
          state          <= IDLE;
          rr_ptr         <= (core_id == IDX_W'(NUM_CORES - 1)) ? '0 : core_id + 1'b1;
          rsp_data       <= '0;
          rsp_err        <= 1'b0;
          l2_opcode      <= OPC_NONE;
          l2_bus_address <= '0;
          l2_bus_data    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Directed bench for l2_bus_arbiter: hit, store, round-robin tie, miss refill, timeout, mid-op reset.
module tb_l2_bus_arbiter;
  import l2_bus_pkg::*;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic              clk;
  logic              reset;
  logic [NC-1:0]     req_valid;
  logic [NC-1:0]     req_is_store;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  req_data;
  logic [NC-1:0]     req_ready;
  logic [NC-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic [6:0]        l2_opcode;
  logic              l2_flush;
  logic [AW-1:0]     l2_bus_address;
  logic [DW-1:0]     l2_bus_data;
  logic [23:0]       l2_bus_tag;
  logic [1:0]        l2_hit;
  logic [DW-1:0]     l2_data;
  logic              busy;
  arb_state_t        state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc_since_grant = 0;
  logic [DW-1:0] exp_q[$];

  l2_bus_arbiter #(
    .NUM_CORES    (NC),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MISS_TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_is_store   (req_is_store),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .l2_opcode      (l2_opcode),
    .l2_flush       (l2_flush),
    .l2_bus_address (l2_bus_address),
    .l2_bus_data    (l2_bus_data),
    .l2_bus_tag     (l2_bus_tag),
    .l2_hit         (l2_hit),
    .l2_data        (l2_data),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_since_grant++;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: present a request on one core (other fields of other cores preserved)
  task automatic drive_req(input int core, input logic is_store, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
    req_valid[core]           = 1'b1;
    req_is_store[core]        = is_store;
    req_addr[core*AW +: AW]   = addr;
    req_data[core*DW +: DW]   = data;
  endtask

  // scoreboard: wait (bounded) for a response and compare it with the expected queue
  task automatic wait_rsp(input int core, input int exp_lat, input logic exp_err);
    logic [DW-1:0] exp_d;
    logic [NC-1:0] exp_v;
    int budget;
    budget = 200;
    while (rsp_valid == '0 && budget > 0) begin
      tick();
      budget--;
    end
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (budget == 0) begin
      check("rsp_timeout", 64'd0, 64'd1);
    end else begin
      exp_v = '0;
      exp_v[core] = 1'b1;
      check("rsp_core", 64'(rsp_valid), 64'(exp_v));
      check("rsp_lat", 64'(cyc_since_grant), 64'(exp_lat));
      check("rsp_data", 64'(rsp_data), 64'(exp_d));
      check("rsp_err", 64'(rsp_err), 64'(exp_err));
      check("rsp_state", 64'(state_dbg), 64'(RESP));
    end
  endtask

  initial begin
    logic [NC-1:0] seen_rsp;
    reset        = 1'b1;
    req_valid    = '0;
    req_is_store = '0;
    req_addr     = '0;
    req_data     = '0;
    l2_hit       = NEUTRAL;
    l2_data      = '0;
    repeat (3) tick();
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);
    check("rst_opc", 64'(l2_opcode), 64'd0);
    check("rst_addr", 64'(l2_bus_address), 64'd0);
    reset = 1'b0;
    tick();
    check("idle_noreq", 64'(req_ready), 64'd0);

    // core0 load hit
    drive_req(0, 1'b0, 32'h0000_0100, 32'h0);
    l2_hit = HIT;
    l2_data = 32'hDEAD_BEEF;
    #1;
    check("ld_ready", 64'(req_ready), 64'b01);
    exp_q.push_back(32'hDEAD_BEEF);
    cyc_since_grant = 0;
    tick();
    req_valid = '0;
    check("ld_state", 64'(state_dbg), 64'(LOAD));
    check("ld_opc", 64'(l2_opcode), 64'(OPC_LOAD));
    check("ld_addr", 64'(l2_bus_address), 64'h100);
    wait_rsp(0, 2, 1'b0);
    tick();
    check("ld_idle", 64'(state_dbg), 64'(IDLE));
    check("ld_idle_addr", 64'(l2_bus_address), 64'd0);
    check("ld_idle_rsp", 64'(rsp_valid), 64'd0);

    // core1 store
    l2_hit = NEUTRAL;
    drive_req(1, 1'b1, 32'h0000_0204, 32'h55);
    #1;
    check("st_ready", 64'(req_ready), 64'b10);
    exp_q.push_back(32'h0);
    cyc_since_grant = 0;
    tick();
    req_valid = '0;
    check("st_flush", 64'(l2_flush), 64'd1);
    check("st_opc", 64'(l2_opcode), 64'd0);
    check("st_tag", 64'(l2_bus_tag), 64'h000002);
    check("st_data", 64'(l2_bus_data), 64'h55);
    wait_rsp(1, 2, 1'b0);
    check("st_flush_once", 64'(l2_flush), 64'd0);
    check("st_tag_hold", 64'(l2_bus_tag), 64'h000002);
    tick();

    // both cores load the same cycle
    drive_req(0, 1'b0, 32'h0000_0300, 32'h0);
    drive_req(1, 1'b0, 32'h0000_0400, 32'h0);
    l2_hit = HIT;
    l2_data = 32'h0000_A0A0;
    #1;
    check("tie_ready0", 64'(req_ready), 64'b01);
    exp_q.push_back(32'h0000_A0A0);
    cyc_since_grant = 0;
    tick();
    req_valid[0] = 1'b0;
    #1;
    check("tie_busy_rdy", 64'(req_ready), 64'd0);
    check("tie_addr0", 64'(l2_bus_address), 64'h300);
    wait_rsp(0, 2, 1'b0);
    tick();
    l2_data = 32'h0000_B0B0;
    #1;
    check("tie_ready1", 64'(req_ready), 64'b10);
    exp_q.push_back(32'h0000_B0B0);
    cyc_since_grant = 0;
    tick();
    req_valid[1] = 1'b0;
    check("tie_addr1", 64'(l2_bus_address), 64'h400);
    wait_rsp(1, 2, 1'b0);
    tick();
    req_valid = 2'b11;
    l2_data = 32'h0000_C0C0;
    #1;
    check("tie_again0", 64'(req_ready), 64'b01);
    exp_q.push_back(32'h0000_C0C0);
    cyc_since_grant = 0;
    tick();
    req_valid = '0;
    wait_rsp(0, 2, 1'b0);
    tick();

    // core1 load miss, three miss cycles then refill hit (rr_ptr now at core1)
    drive_req(1, 1'b0, 32'h0000_0500, 32'h0);
    l2_hit = MISS;
    #1;
    check("miss_ready", 64'(req_ready), 64'b10);
    exp_q.push_back(32'h0000_1234);
    cyc_since_grant = 0;
    tick();
    req_valid = '0;
    tick();
    check("miss_state", 64'(state_dbg), 64'(MISS_WAIT));
    check("miss_opc", 64'(l2_opcode), 64'(OPC_LOAD));
    tick();
    tick();
    l2_hit = HIT;
    l2_data = 32'h0000_1234;
    wait_rsp(1, 5, 1'b0);
    l2_hit = NEUTRAL;
    tick();

    // core0 load never refilled; neutral hit code in LOAD counts as miss
    drive_req(0, 1'b0, 32'h0000_0600, 32'h0);
    l2_hit = NEUTRAL;
    #1;
    check("to_ready", 64'(req_ready), 64'b01);
    exp_q.push_back(32'h0);
    cyc_since_grant = 0;
    tick();
    req_valid = '0;
    wait_rsp(0, 2 + TO, 1'b1);
    tick();
    check("to_idle", 64'(state_dbg), 64'(IDLE));
    check("to_idle_err", 64'(rsp_err), 64'd0);

    // reset while in MISS_WAIT (rr_ptr at core1)
    drive_req(1, 1'b0, 32'h0000_0700, 32'h0);
    l2_hit = MISS;
    #1;
    check("rm_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("rm_pre_state", 64'(state_dbg), 64'(MISS_WAIT));
    reset = 1'b1;
    tick();
    check("rm_state", 64'(state_dbg), 64'(IDLE));
    check("rm_rsp", 64'(rsp_valid), 64'd0);
    check("rm_opc", 64'(l2_opcode), 64'd0);
    check("rm_addr", 64'(l2_bus_address), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    seen_rsp = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_rsp = seen_rsp | rsp_valid;
    end
    check("rm_no_rsp", 64'(seen_rsp), 64'd0);

    // after reset rr_ptr is back at core0
    req_valid = 2'b11;
    #1;
    check("rm_rr_ptr", 64'(req_ready), 64'b01);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
